// File: rtl/add64_seq_arbiter_pkg.sv
// Shared definitions for the slice-serial 64-bit adder with a two-requester round-robin arbiter.
package add64_seq_arbiter_pkg;

  localparam int NREQ        = 2;
  localparam int DEF_W       = 64;
  localparam int DEF_SLICE_W = 16;
  localparam int DEF_NSLICE  = DEF_W / DEF_SLICE_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add64_seq_arbiter_if.sv
// Request/result bus between the operand producers, the arbiter and the result consumer.
interface add64_seq_arbiter_if #(parameter int W = add64_seq_arbiter_pkg::DEF_W) ();
  import add64_seq_arbiter_pkg::*;

  logic [NREQ-1:0] in_valid;
  logic [NREQ-1:0] in_ready;
  logic [W-1:0]    a0;
  logic [W-1:0]    b0;
  logic            cin0;
  logic [W-1:0]    a1;
  logic [W-1:0]    b1;
  logic            cin1;
  logic            out_valid;
  logic            out_ready;
  logic            out_id;
  logic [W-1:0]    sum;
  logic            cout;

  modport master (
    output in_valid, a0, b0, cin0, a1, b1, cin1, out_ready,
    input  in_ready, out_valid, out_id, sum, cout
  );

  modport slave (
    input  in_valid, a0, b0, cin0, a1, b1, cin1, out_ready,
    output in_ready, out_valid, out_id, sum, cout
  );

endinterface

// File: rtl/add64_seq_arbiter_add_slice.sv
// Combinational ripple-carry adder slice built from a chain of full-adder cells.
module add_slice #(
  parameter int SLICE_W = 16
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [SLICE_W:0] carry_s;

  assign carry_s[0] = cin;

  for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
    assign sum[i]         = a[i] ^ b[i] ^ carry_s[i];
    assign carry_s[i + 1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
  end

  assign cout = carry_s[SLICE_W];

endmodule

// File: rtl/add64_seq_arbiter.sv
// Round-robin arbiter feeding one shared adder slice; a full W-bit add takes NSLICE cycles, LS slice first.
module add64_seq_arbiter
  import add64_seq_arbiter_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int SLICE_W = DEF_SLICE_W
) (
  input logic              clk,
  input logic              rst_n,
  add64_seq_arbiter_if.slave bus
);

  localparam int NSLICE = W / SLICE_W;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

  state_t              state_r;
  state_t              state_nxt_s;
  logic                ptr_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                carry_r;
  logic [W-1:0]        a_r;
  logic [W-1:0]        b_r;
  logic [W-1:0]        sum_r;
  logic                cout_r;
  logic                out_id_r;
  logic                out_valid_r;
  logic [NREQ-1:0]     grant_s;
  logic                hs_s;
  logic                hs_id_s;
  logic [SLICE_W-1:0]  slice_a_s;
  logic [SLICE_W-1:0]  slice_b_s;
  logic [SLICE_W-1:0]  slice_sum_s;
  logic                slice_cout_s;

  // Grant: a lone requester wins; on contention the pointer picks; nothing outside IDLE.
  always_comb begin
    grant_s = 2'b00;
    if (state_r == ST_IDLE) begin
      case (bus.in_valid)
        2'b01:   grant_s = 2'b01;
        2'b10:   grant_s = 2'b10;
        2'b11:   grant_s = ptr_r ? 2'b10 : 2'b01;
        default: grant_s = 2'b00;
      endcase
    end else begin
      grant_s = 2'b00;
    end
  end

  assign hs_s         = |(bus.in_valid & grant_s);
  assign hs_id_s      = grant_s[1];
  assign bus.in_ready = grant_s;

  assign slice_a_s = a_r[cnt_r * SLICE_W +: SLICE_W];
  assign slice_b_s = b_r[cnt_r * SLICE_W +: SLICE_W];

  add_slice #(.SLICE_W(SLICE_W)) u_slice (
    .a    (slice_a_s),
    .b    (slice_b_s),
    .cin  (carry_r),
    .sum  (slice_sum_s),
    .cout (slice_cout_s)
  );

  // Next-state selection.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (hs_s) state_nxt_s = ST_CALC;
        else      state_nxt_s = ST_IDLE;
      end
      ST_CALC: begin
        if (cnt_r == LAST_SLICE) state_nxt_s = ST_DONE;
        else                     state_nxt_s = ST_CALC;
      end
      ST_DONE: begin
        if (bus.out_ready) state_nxt_s = ST_IDLE;
        else               state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Operand capture, slice accumulation and result hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_r       <= 1'b0;
      cnt_r       <= {CNT_W{1'b0}};
      carry_r     <= 1'b0;
      a_r         <= {W{1'b0}};
      b_r         <= {W{1'b0}};
      sum_r       <= {W{1'b0}};
      cout_r      <= 1'b0;
      out_id_r    <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (hs_s) begin
            a_r      <= hs_id_s ? bus.a1   : bus.a0;
            b_r      <= hs_id_s ? bus.b1   : bus.b0;
            carry_r  <= hs_id_s ? bus.cin1 : bus.cin0;
            out_id_r <= hs_id_s;
            ptr_r    <= ~hs_id_s;
            cnt_r    <= {CNT_W{1'b0}};
          end
        end
        ST_CALC: begin
          sum_r[cnt_r * SLICE_W +: SLICE_W] <= slice_sum_s;
          carry_r                           <= slice_cout_s;
          if (cnt_r == LAST_SLICE) begin
            cout_r      <= slice_cout_s;
            out_valid_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          if (bus.out_ready) out_valid_r <= 1'b0;
        end
        default: out_valid_r <= 1'b0;
      endcase
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_id    = out_id_r;
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;

endmodule

// File: tb/tb_add64_seq_arbiter.sv
// Scoreboard bench: directed cases from the test plan, then randomized traffic against a 65-bit arithmetic model.
module tb_add64_seq_arbiter;
  import add64_seq_arbiter_pkg::*;

  localparam int W   = DEF_W;
  localparam int LAT = DEF_NSLICE;

  typedef struct packed {
    logic         id;
    logic [W-1:0] sum;
    logic         cout;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   hs_cyc = 0;
  int   hs_cyc_prev = 0;
  int   last_wait = 0;
  logic ptr_m = 1'b0;
  bit   rand_bp = 1'b0;
  bit   hold_ops = 1'b0;
  exp_t last_exp;
  exp_t sb_q[$];
  logic gid;

  add64_seq_arbiter_if #(.W(W)) bus ();

  add64_seq_arbiter #(.W(W), .SLICE_W(DEF_SLICE_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [1:0] model_grant(input logic [1:0] v, input logic p);
    if (v == 2'b11) return p ? 2'b10 : 2'b01;
    else            return v;
  endfunction

  function automatic exp_t model_add(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic c);
    logic [W:0] full;
    exp_t       e;
    full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    e.id   = id;
    e.sum  = full[W-1:0];
    e.cout = full[W];
    return e;
  endfunction

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 3))
      0:       return {W{1'b1}};
      1:       return {W{1'b0}};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (rand_bp) bus.out_ready = 1'($urandom);
    #1;
  endtask

  task automatic randomize_ops();
    bus.a0   = rand_op();
    bus.b0   = rand_op();
    bus.cin0 = 1'($urandom);
    bus.a1   = rand_op();
    bus.b1   = rand_op();
    bus.cin1 = 1'($urandom);
  endtask

  // Result monitor: pops the oldest expectation whenever a result is consumed.
  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got id %0d sum %0h, expected no result", bus.out_id, bus.sum);
        end else begin
          e = sb_q.pop_front();
          check("out_id", bus.out_id, e.id);
          check("sum",    bus.sum,    e.sum);
          check("cout",   bus.cout,   e.cout);
        end
      end
    end
  endtask

  task automatic issue(input logic [1:0] v, input bit push, output logic id);
    int         t;
    logic [1:0] g;
    bus.in_valid = v;
    #1;
    t  = 0;
    id = 1'b0;
    while (bus.in_ready == 2'b00 && t < 100) begin
      step();
      t++;
    end
    if (t >= 100) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: in_ready %b, expected a grant for in_valid %b", bus.in_ready, v);
    end else begin
      g = model_grant(bus.in_valid, ptr_m);
      check("in_ready_grant", bus.in_ready, g);
      id          = g[1];
      last_wait   = t;
      hs_cyc_prev = hs_cyc;
      hs_cyc      = cyc;
      last_exp    = id ? model_add(1'b1, bus.a1, bus.b1, bus.cin1)
                       : model_add(1'b0, bus.a0, bus.b0, bus.cin0);
      if (push) sb_q.push_back(last_exp);
      ptr_m = ~id;
      @(posedge clk);
      #1;
      if (!hold_ops) randomize_ops();
    end
  endtask

  task automatic check_latency();
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk);
      #1;
      check("latency_out_valid", bus.out_valid, (k == LAT));
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 300) begin
      step();
      t++;
    end
    check("drain_pending", sb_q.size(), 0);
  endtask

  initial begin
    bus.in_valid  = 2'b00;
    bus.out_ready = 1'b1;
    bus.a0 = {W{1'b0}}; bus.b0 = {W{1'b0}}; bus.cin0 = 1'b0;
    bus.a1 = {W{1'b0}}; bus.b1 = {W{1'b0}}; bus.cin1 = 1'b0;
    fork
      monitor_loop();
    join_none

    // Reset, then idle.
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_sum", bus.sum, {W{1'b0}});
    check("rst_cout", bus.cout, 1'b0);
    check("rst_out_id", bus.out_id, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_in_ready", bus.in_ready, 2'b00);
      check("idle_out_valid", bus.out_valid, 1'b0);
    end

    // Carry crossing a slice boundary.
    bus.a0 = 64'h0000_0000_0000_FFFF; bus.b0 = 64'h0000_0000_0000_0001; bus.cin0 = 1'b0;
    issue(2'b01, 1'b1, gid);
    bus.in_valid = 2'b00;
    check_latency();
    drain();

    // Full wrap-around on requester 1.
    bus.a1 = {W{1'b1}}; bus.b1 = {W{1'b1}}; bus.cin1 = 1'b1;
    issue(2'b10, 1'b1, gid);
    bus.in_valid = 2'b00;
    check_latency();
    drain();

    // Both requesters continuously valid: grants alternate, issue every LAT+2 cycles.
    hold_ops = 1'b1;
    bus.a0 = 64'hA004_1020_021B_00C0; bus.b0 = 64'h0F01_0000_100F_DA11; bus.cin0 = 1'b1;
    bus.a1 = 64'h1103_4501_1110_0000; bus.b1 = 64'h01A4_608D_0001_1111; bus.cin1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      issue(2'b11, 1'b1, gid);
      if (i > 0) check("issue_interval", hs_cyc - hs_cyc_prev, LAT + 2);
    end
    bus.in_valid = 2'b00;
    hold_ops = 1'b0;
    drain();

    // Back-pressure holds the result and blocks new grants.
    bus.out_ready = 1'b0;
    randomize_ops();
    issue(2'b01, 1'b1, gid);
    bus.in_valid = 2'b10;
    check_latency();
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_out_valid", bus.out_valid, 1'b1);
      check("bp_sum", bus.sum, last_exp.sum);
      check("bp_cout", bus.cout, last_exp.cout);
      check("bp_out_id", bus.out_id, last_exp.id);
      check("bp_in_ready", bus.in_ready, 2'b00);
    end
    bus.out_ready = 1'b1;
    step();
    check("bp_release_out_valid", bus.out_valid, 1'b0);
    issue(2'b10, 1'b1, gid);
    check("bp_next_accept_wait", last_wait, 0);
    bus.in_valid = 2'b00;
    drain();

    // Reset while slice 2 is being computed abandons the operation and clears the pointer.
    randomize_ops();
    issue(2'b01, 1'b0, gid);
    bus.in_valid = 2'b00;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    ptr_m = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("abort_out_valid", bus.out_valid, 1'b0);
      check("abort_in_ready", bus.in_ready, 2'b00);
    end
    issue(2'b11, 1'b1, gid);
    bus.in_valid = 2'b00;
    check_latency();
    drain();

    // Randomized traffic with random back-pressure.
    rand_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      issue(2'($urandom_range(1, 3)), 1'b1, gid);
      if ($urandom_range(0, 1) == 1) bus.in_valid = 2'b00;
      for (int j = $urandom_range(0, 2); j > 0; j--) step();
    end
    bus.in_valid = 2'b00;
    rand_bp = 1'b0;
    bus.out_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
